// File: rtl/transmissor_ataque.sv
// Serial attack initiator: sends a row/column frame and decodes the 2-bit reply.
// Define PARIDADE_EN to add even parity to both the outgoing frame and the reply.
module transmissor_ataque #(
  parameter int CICLOS_POR_BIT = 16,
  parameter int TIMEOUT_BITS   = 64
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic [2:0] coordLinha,
  input  logic [2:0] coordColuna,
  input  logic       confirmar,
  input  logic       rx,
  output logic       tx,
  output logic       ocupado,
  output logic       resposta_valida,
  output logic       acerto,
  output logic       repetido,
  output logic       erro,
  output logic [1:0] cod_erro
);
`ifdef PARIDADE_EN
  localparam int TX_BITS = 9;
  localparam int RX_BITS = 4;
`else
  localparam int TX_BITS = 8;
  localparam int RX_BITS = 3;
`endif
  localparam int CW   = $clog2(CICLOS_POR_BIT + 1);
  localparam int TOUT = TIMEOUT_BITS * CICLOS_POR_BIT;
  localparam int TW   = $clog2(TOUT + 1);
  localparam int MEIO = CICLOS_POR_BIT / 2;

  typedef enum logic [2:0] {OCIOSO, ENVIA, AGUARDA, RECEBE, CONCLUI} estado_t;

  estado_t              estado_q, estado_d;
  logic                 rx_s1_q, rx_s2_q, rx_ant_q;
  logic [TX_BITS-1:0]   quadro_q, quadro_d;
  logic [3:0]           bit_q, bit_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [TW-1:0]        to_q, to_d;
  logic                 chk_q, chk_d;
  logic [RX_BITS-2:0]   dados_q, dados_d;
  logic                 acerto_q, acerto_d, repetido_q, repetido_d;
  logic                 erro_q, erro_d, rv_q, rv_d;
  logic [1:0]           cod_q, cod_d;
  logic                 fora, falha, par_ok;
  logic [TX_BITS-1:0]   quadro_novo;

  assign fora = (coordLinha > 3'd6) || (coordColuna > 3'd4);
`ifdef PARIDADE_EN
  assign quadro_novo = {1'b1, ^{coordColuna, coordLinha}, coordColuna, coordLinha, 1'b0};
  assign par_ok      = ~(^dados_q);
`else
  assign quadro_novo = {1'b1, coordColuna, coordLinha, 1'b0};
  assign par_ok      = 1'b1;
`endif
  // dados_q[0] is the first data bit received (acerto), [1] is repetido
  assign falha = !rx_s2_q || (dados_q[0] && dados_q[1]) || !par_ok;

  always_ff @(posedge clock_in) begin
    if (!reset_n) estado_q <= OCIOSO;
    else          estado_q <= estado_d;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_ant_q <= 1'b1;
      quadro_q <= '1; bit_q <= '0; cyc_q <= '0; to_q <= '0; chk_q <= 1'b0;
      dados_q <= '0; acerto_q <= 1'b0; repetido_q <= 1'b0;
      erro_q <= 1'b0; rv_q <= 1'b0; cod_q <= 2'b00;
    end else begin
      rx_s1_q <= rx; rx_s2_q <= rx_s1_q; rx_ant_q <= rx_s2_q;
      quadro_q <= quadro_d; bit_q <= bit_d; cyc_q <= cyc_d; to_q <= to_d; chk_q <= chk_d;
      dados_q <= dados_d; acerto_q <= acerto_d; repetido_q <= repetido_d;
      erro_q <= erro_d; rv_q <= rv_d; cod_q <= cod_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    quadro_d = quadro_q; bit_d = bit_q; cyc_d = cyc_q; to_d = to_q; chk_d = chk_q;
    dados_d = dados_q; acerto_d = acerto_q; repetido_d = repetido_q; cod_d = cod_q;
    erro_d = 1'b0; rv_d = 1'b0;
    case (estado_q)
      OCIOSO: if (confirmar) begin
        acerto_d = 1'b0; repetido_d = 1'b0; cod_d = 2'b00;
        if (fora) begin
          erro_d = 1'b1; cod_d = 2'b01;
        end else begin
          quadro_d = quadro_novo; bit_d = '0; cyc_d = '0; estado_d = ENVIA;
        end
      end
      ENVIA: if (cyc_q == CW'(CICLOS_POR_BIT - 1)) begin
        cyc_d = '0;
        if (bit_q == 4'(TX_BITS - 1)) begin
          estado_d = AGUARDA; to_d = '0; chk_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1; quadro_d = {1'b1, quadro_q[TX_BITS-1:1]};
        end
      end else cyc_d = cyc_q + CW'(1);
      AGUARDA: begin
        // timeout keeps running through a start-bit check, so glitches never extend the wait
        to_d = to_q + TW'(1);
        if (to_q == TW'(TOUT - 1)) begin
          estado_d = CONCLUI; erro_d = 1'b1; cod_d = 2'b10;
        end else if (chk_q) begin
          if (cyc_q == CW'(MEIO)) begin
            chk_d = 1'b0;
            if (!rx_s2_q) begin
              estado_d = RECEBE; cyc_d = CW'(1); bit_d = '0;
            end
          end else cyc_d = cyc_q + CW'(1);
        end else if (rx_ant_q && !rx_s2_q) begin
          chk_d = 1'b1; cyc_d = CW'(1);
        end
      end
      RECEBE: if (cyc_q == CW'(CICLOS_POR_BIT)) begin
        cyc_d = CW'(1);
        if (bit_q == 4'(RX_BITS - 1)) begin
          estado_d = CONCLUI;
          if (falha) begin
            erro_d = 1'b1; cod_d = 2'b11;
          end else begin
            acerto_d = dados_q[0]; repetido_d = dados_q[1]; rv_d = 1'b1;
          end
        end else begin
          if (RX_BITS > 3) dados_d = {rx_s2_q, dados_q[RX_BITS-2:1]};
          else             dados_d = {rx_s2_q, dados_q[RX_BITS-2]};
          bit_d = bit_q + 4'd1;
        end
      end else cyc_d = cyc_q + CW'(1);
      CONCLUI: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    tx              = (estado_q == ENVIA) ? quadro_q[0] : 1'b1;
    ocupado         = (estado_q != OCIOSO);
    resposta_valida = rv_q;
    erro            = erro_q;
    acerto          = acerto_q;
    repetido        = repetido_q;
    cod_erro        = cod_q;
  end
endmodule

// File: tb/tb_transmissor_ataque.sv
// Directed bench for transmissor_ataque with CICLOS_POR_BIT=4, TIMEOUT_BITS=8.
module tb_transmissor_ataque;
`ifdef PARIDADE_EN
  localparam int NTX = 9;
`else
  localparam int NTX = 8;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] lin = 3'd0, col = 3'd0;
  logic conf = 1'b0, rx = 1'b1;
  logic tx, ocupado, rv, acerto, repetido, erro;
  logic [1:0] cod;
  int checks = 0, errors = 0;

  transmissor_ataque #(.CICLOS_POR_BIT(4), .TIMEOUT_BITS(8)) dut (
    .clock_in(clk), .reset_n(rst_n), .coordLinha(lin), .coordColuna(col),
    .confirmar(conf), .rx(rx), .tx(tx), .ocupado(ocupado),
    .resposta_valida(rv), .acerto(acerto), .repetido(repetido),
    .erro(erro), .cod_erro(cod));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues a request and checks every tx cycle; optionally pokes confirmar mid-frame.
  task automatic send_frame(input logic [2:0] l, input logic [2:0] c,
                            input logic [8:0] exp, input bit inject);
    lin = l; col = c; conf = 1'b1;
    tick(); conf = 1'b0;
    for (int b = 0; b < NTX; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (inject && b == 3 && k == 1) begin conf = 1'b1; lin = 3'd0; col = 3'd0; end
        checks++;
        if (tx !== exp[b] || ocupado !== 1'b1) begin
          errors++;
          $display("FAIL frame bit%0d cyc%0d tx=%b ocupado=%b want tx=%b ocupado=1", b, k, tx, ocupado, exp[b]);
        end
        tick(); conf = 1'b0;
      end
    end
  endtask

  // Drives reply bits (bits[0] first), then idles one cycle: lands in the completion cycle.
  task automatic send_reply(input logic [4:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (4) tick();
    end
    rx = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (tx !== 1'b1 || ocupado !== 1'b0 || acerto !== 1'b0 || repetido !== 1'b0 ||
          cod !== 2'b00 || erro !== 1'b0 || rv !== 1'b0) begin
        errors++;
        $display("FAIL reset tx=%b oc=%b ac=%b rep=%b cod=%b erro=%b rv=%b want 1 0 0 0 00 0 0",
                 tx, ocupado, acerto, repetido, cod, erro, rv);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_out_of_range();
    lin = 3'd7; col = 3'd0; conf = 1'b1;
    tick(); conf = 1'b0;
    checks++;
    if (erro !== 1'b1 || cod !== 2'b01 || ocupado !== 1'b0 || tx !== 1'b1 || rv !== 1'b0) begin
      errors++;
      $display("FAIL range_pulse erro=%b cod=%b oc=%b tx=%b rv=%b want 1 01 0 1 0", erro, cod, ocupado, tx, rv);
    end
    tick();
    checks++;
    if (erro !== 1'b0 || cod !== 2'b01 || ocupado !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL range_after erro=%b cod=%b oc=%b tx=%b want 0 01 0 1", erro, cod, ocupado, tx);
    end
  endtask

  task automatic test_reset_mid_frame();
    lin = 3'd1; col = 3'd1; conf = 1'b1;
    tick(); conf = 1'b0;
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (tx !== 1'b1 || ocupado !== 1'b0 || erro !== 1'b0 || rv !== 1'b0 || cod !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid tx=%b oc=%b erro=%b rv=%b cod=%b want 1 0 0 0 00", tx, ocupado, erro, rv, cod);
    end
    rst_n = 1'b1;
    tick();
  endtask

`ifndef PARIDADE_EN
  task automatic test_hit();
    send_frame(3'd3, 3'd2, 9'b010100110, 1'b1);
    send_reply(5'b01010, 4);
    checks++;
    if (rv !== 1'b1 || erro !== 1'b0 || acerto !== 1'b1 || repetido !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse rv=%b erro=%b ac=%b rep=%b want 1 0 1 0", rv, erro, acerto, repetido);
    end
    tick();
    checks++;
    if (rv !== 1'b0 || ocupado !== 1'b0 || acerto !== 1'b1 || cod !== 2'b00) begin
      errors++;
      $display("FAIL hit_after rv=%b oc=%b ac=%b cod=%b want 0 0 1 00", rv, ocupado, acerto, cod);
    end
  endtask

  task automatic test_timeout();
    send_frame(3'd2, 3'd4, 9'b011000100, 1'b0);
    repeat (31) tick();
    checks++;
    if (erro !== 1'b0 || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early erro=%b oc=%b want 0 1", erro, ocupado);
    end
    tick();
    checks++;
    if (erro !== 1'b1 || cod !== 2'b10 || rv !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse erro=%b cod=%b rv=%b want 1 10 0", erro, cod, rv);
    end
    tick();
    checks++;
    if (erro !== 1'b0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after erro=%b oc=%b want 0 0", erro, ocupado);
    end
  endtask

  task automatic test_glitch();
    send_frame(3'd0, 3'd0, 9'b010000000, 1'b0);
    repeat (2) tick();
    rx = 1'b0; tick(); rx = 1'b1;
    repeat (4) tick();
    checks++;
    if (ocupado !== 1'b1 || erro !== 1'b0 || rv !== 1'b0) begin
      errors++;
      $display("FAIL glitch_wait oc=%b erro=%b rv=%b want 1 0 0", ocupado, erro, rv);
    end
    send_reply(5'b01100, 4);
    checks++;
    if (rv !== 1'b1 || repetido !== 1'b1 || acerto !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reply rv=%b rep=%b ac=%b erro=%b want 1 1 0 0", rv, repetido, acerto, erro);
    end
    tick();
  endtask

  task automatic test_bad_reply();
    send_frame(3'd6, 3'd4, 9'b011001100, 1'b0);
    send_reply(5'b01110, 4);
    checks++;
    if (erro !== 1'b1 || rv !== 1'b0 || cod !== 2'b11 || acerto !== 1'b0 || repetido !== 1'b0) begin
      errors++;
      $display("FAIL code11 erro=%b rv=%b cod=%b ac=%b rep=%b want 1 0 11 0 0", erro, rv, cod, acerto, repetido);
    end
    tick();
    send_frame(3'd1, 3'd1, 9'b010010010, 1'b0);
    send_reply(5'b00010, 4);
    checks++;
    if (erro !== 1'b1 || rv !== 1'b0 || cod !== 2'b11 || acerto !== 1'b0) begin
      errors++;
      $display("FAIL stop0 erro=%b rv=%b cod=%b ac=%b want 1 0 11 0", erro, rv, cod, acerto);
    end
    tick();
  endtask
`else
  task automatic test_parity();
    send_frame(3'd1, 3'd0, 9'b110000010, 1'b0);
    send_reply(5'b11010, 5);
    checks++;
    if (rv !== 1'b1 || acerto !== 1'b1 || repetido !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL par_ok rv=%b ac=%b rep=%b erro=%b want 1 1 0 0", rv, acerto, repetido, erro);
    end
    tick();
    send_frame(3'd1, 3'd0, 9'b110000010, 1'b0);
    send_reply(5'b10010, 5);
    checks++;
    if (erro !== 1'b1 || rv !== 1'b0 || cod !== 2'b11 || acerto !== 1'b0) begin
      errors++;
      $display("FAIL par_bad erro=%b rv=%b cod=%b ac=%b want 1 0 11 0", erro, rv, cod, acerto);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifndef PARIDADE_EN
    test_hit();
    test_out_of_range();
    test_timeout();
    test_glitch();
    test_bad_reply();
`else
    test_out_of_range();
    test_parity();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
